// File: rtl/btn_pkg.sv
// Shared types and default timings for the button event block.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_e;

    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b);
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Registered-level edge detector; the level register resets high so an
// input already asserted through reset is not reported as a rising edge.
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/btn_event.sv
// Debounced button level to press/release/short/long pulse events.
// Auto-repeat in LONG is built only when BTN_EVENT_REPEAT_EN is defined.
module btn_event
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

    btn_state_e     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic rise, fall;
    logic press_d, release_d, short_d, long_d, held_d;

    btn_edge_det u_edge (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .level (btn_i),
        .rise  (rise),
        .fall  (fall)
    );

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_d, repeat_q;
`endif

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt == LONG_MAX) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else if (!press_o) begin
                    // the cycle carrying press_o is not part of the hold
                    cnt_d = cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_EVENT_REPEAT_EN
                    if (cnt == REP_MAX) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            press_o   <= press_d;
            release_o <= release_d;
            short_o   <= short_d;
            long_o    <= long_d;
            held_o    <= held_d;
        end
    end

`ifdef BTN_EVENT_REPEAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule
